// File: rtl/fp4_cquant.sv
// Streaming complex quantizer: signed fixed-point complex samples to packed FP4 E2M1 pairs.
// Two register stages (magnitude/sign, then encoded codes) with a valid/ready handshake.
module fp4_cquant #(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_real,
    input  logic signed [WIDTH-1:0] in_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_real,
    output logic [3:0]              out_imag,
    output logic [CNT_W-1:0]        sat_count,
    input  logic                    clr_count
);
    // One extra bit so that |most negative input| is representable.
    localparam int MW = WIDTH + 1;

    // Rounding midpoints and the saturation limit, scaled by 2^FRAC_BITS.
    localparam logic [MW-1:0] T_0P5  = MW'(1 << (FRAC_BITS - 1));
    localparam logic [MW-1:0] T_1P25 = MW'(5 << (FRAC_BITS - 2));
    localparam logic [MW-1:0] T_1P75 = MW'(7 << (FRAC_BITS - 2));
    localparam logic [MW-1:0] T_2P5  = MW'(5 << (FRAC_BITS - 1));
    localparam logic [MW-1:0] T_3P5  = MW'(7 << (FRAC_BITS - 1));
    localparam logic [MW-1:0] T_5P0  = MW'(5 << FRAC_BITS);
    localparam logic [MW-1:0] T_6P0  = MW'(6 << FRAC_BITS);

    function automatic logic [MW-1:0] abs_mag(input logic signed [WIDTH-1:0] x);
        logic signed [MW-1:0] xe;
        xe = {x[WIDTH-1], x};
        return x[WIDTH-1] ? MW'(-xe) : MW'(xe);
    endfunction

    // Round to nearest, ties toward larger magnitude.
    function automatic logic [2:0] enc_mag(input logic [MW-1:0] m);
        if (m < T_0P5)       return 3'b000;
        else if (m < T_1P25) return 3'b010;
        else if (m < T_1P75) return 3'b011;
        else if (m < T_2P5)  return 3'b100;
        else if (m < T_3P5)  return 3'b101;
        else if (m < T_5P0)  return 3'b110;
        else                 return 3'b111;
    endfunction

    function automatic logic [3:0] pack_fp4(input logic s, input logic [2:0] code);
        return {s & (code != 3'b000), code};
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic           s1_valid_q;
    logic           sign_re_p1_q, sign_im_p1_q;
    logic [MW-1:0]  mag_re_p1_q, mag_im_p1_q;
    logic           out_valid_q;
    logic [3:0]     out_real_q, out_imag_q;
    logic [CNT_W-1:0] sat_count_q, sat_count_d;
    logic           adv1, adv2, in_fire, s12_fire;
    logic [1:0]     sat_inc;

    assign adv2     = !out_valid_q | out_ready;
    assign adv1     = !s1_valid_q | adv2;
    assign in_ready = adv1;
    assign in_fire  = in_valid & adv1;
    assign s12_fire = s1_valid_q & adv2;

    assign sat_inc = {1'b0, mag_re_p1_q > T_6P0} + {1'b0, mag_im_p1_q > T_6P0};

    always_comb begin
        sat_count_d = sat_count_q;
        if (clr_count)
            sat_count_d = '0;
        else if (s12_fire)
            sat_count_d = sat_add(sat_count_q, sat_inc);
    end

    // Stage 1: sign and magnitude
    always_ff @(posedge clk) begin
        if (rst)
            s1_valid_q <= 1'b0;
        else if (adv1)
            s1_valid_q <= in_valid;
        if (in_fire) begin
            sign_re_p1_q <= in_real[WIDTH-1];
            sign_im_p1_q <= in_imag[WIDTH-1];
            mag_re_p1_q  <= abs_mag(in_real);
            mag_im_p1_q  <= abs_mag(in_imag);
        end
    end

    // Stage 2: encoded FP4 codes and saturation accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_real_q  <= 4'b0000;
            out_imag_q  <= 4'b0000;
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
            if (adv2)
                out_valid_q <= s1_valid_q;
            if (s12_fire) begin
                out_real_q <= pack_fp4(sign_re_p1_q, enc_mag(mag_re_p1_q));
                out_imag_q <= pack_fp4(sign_im_p1_q, enc_mag(mag_im_p1_q));
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign sat_count = sat_count_q;
endmodule

// File: tb/tb_fp4_cquant.sv
// Directed self-checking bench for fp4_cquant (WIDTH=8, FRAC_BITS=4, CNT_W=16).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_fp4_cquant;
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_real;
    logic signed [7:0] in_imag;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_real;
    logic [3:0]        out_imag;
    logic [15:0]       sat_count;
    logic              clr_count;

    int checks   = 0;
    int failures = 0;

    fp4_cquant #(.WIDTH(8), .FRAC_BITS(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .sat_count(sat_count), .clr_count(clr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for one cycle, then wait for it to reach the output.
    task automatic send_one(input logic signed [7:0] re, input logic signed [7:0] im);
        in_real  = re;
        in_imag  = im;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_real  = 8'sd0;
        in_imag  = 8'sd0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
        in_real = 8'sd0; in_imag = 8'sd0;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_real !== 4'b0000) begin failures++; $display("FAIL reset_out_real got=%b exp=0000", out_real); end
        checks++; if (out_imag !== 4'b0000) begin failures++; $display("FAIL reset_out_imag got=%b exp=0000", out_imag); end
        checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL reset_sat_count got=%0d exp=0", sat_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_latency();
        in_real = 8'sd24; in_imag = -8'sd40; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_valid got=%b exp=1", out_valid); end
        checks++; if (out_real !== 4'b0011) begin failures++; $display("FAIL latency_real got=%b exp=0011", out_real); end
        checks++; if (out_imag !== 4'b1101) begin failures++; $display("FAIL latency_imag got=%b exp=1101", out_imag); end
        checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL latency_sat got=%0d exp=0", sat_count); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_single got=%b exp=0", out_valid); end
    endtask

    task automatic test_rounding();
        logic signed [7:0] vin  [12];
        logic        [3:0] vexp [12];
        vin = '{8'sd20, 8'sd8, -8'sd7, 8'sd80, 8'sd7, 8'sd19, 8'sd27, 8'sd28, 8'sd55, 8'sd56, 8'sd79, 8'sd96};
        vexp = '{4'b0011, 4'b0010, 4'b0000, 4'b0111, 4'b0000, 4'b0010, 4'b0011, 4'b0100,
                 4'b0101, 4'b0110, 4'b0110, 4'b0111};
        for (int i = 0; i < 12; i++) begin
            // Imag carries the negated value; flushed magnitudes must lose the sign.
            send_one(vin[i], -vin[i]);
            checks++; if (out_real !== vexp[i]) begin failures++; $display("FAIL round_real[%0d] in=%0d got=%b exp=%b", i, vin[i], out_real, vexp[i]); end
            checks++; if (out_imag !== ((vexp[i][2:0] == 3'b000) ? 4'b0000 : {1'b1, vexp[i][2:0]}))
                begin failures++; $display("FAIL round_imag[%0d] in=%0d got=%b", i, -vin[i], out_imag); end
        end
        checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL round_no_sat got=%0d exp=0", sat_count); end
    endtask

    task automatic test_saturation();
        send_one(8'sd127, -8'sd128);
        checks++; if (out_real !== 4'b0111) begin failures++; $display("FAIL sat_real got=%b exp=0111", out_real); end
        checks++; if (out_imag !== 4'b1111) begin failures++; $display("FAIL sat_imag got=%b exp=1111", out_imag); end
        checks++; if (sat_count !== 16'd2) begin failures++; $display("FAIL sat_count_two got=%0d exp=2", sat_count); end
        send_one(8'sd97, 8'sd96);
        checks++; if (out_real !== 4'b0111 || out_imag !== 4'b0111) begin failures++; $display("FAIL sat_edge got=%b/%b exp=0111/0111", out_real, out_imag); end
        checks++; if (sat_count !== 16'd3) begin failures++; $display("FAIL sat_count_edge got=%0d exp=3", sat_count); end
    endtask

    task automatic test_clamp_and_clear();
        clr_count = 1'b1; step(); clr_count = 1'b0;
        checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL clr_plain got=%0d exp=0", sat_count); end
        in_real = 8'sd127; in_imag = -8'sd128; in_valid = 1'b1;
        for (int i = 0; i < 32767; i++) step();
        in_valid = 1'b0;
        step(); step();
        checks++; if (sat_count !== 16'hFFFE) begin failures++; $display("FAIL clamp_preload got=%0d exp=65534", sat_count); end
        send_one(8'sd127, -8'sd128);
        checks++; if (sat_count !== 16'hFFFF) begin failures++; $display("FAIL clamp_overflow got=%0d exp=65535", sat_count); end
        send_one(-8'sd128, 8'sd127);
        checks++; if (sat_count !== 16'hFFFF) begin failures++; $display("FAIL clamp_hold got=%0d exp=65535", sat_count); end
        // Clear coincides with the stage1->stage2 transfer of a saturating pair.
        in_real = 8'sd127; in_imag = -8'sd128; in_valid = 1'b1;
        step();
        in_valid = 1'b0; clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL clr_wins got=%0d exp=0", sat_count); end
        checks++; if (out_valid !== 1'b1 || out_real !== 4'b0111 || out_imag !== 4'b1111)
            begin failures++; $display("FAIL clr_sample got=%b %b/%b exp=1 0111/1111", out_valid, out_real, out_imag); end
        step();
        checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL clr_after got=%0d exp=0", sat_count); end
    endtask

    task automatic test_back_to_back();
        logic signed [7:0] re_t [5];
        logic signed [7:0] im_t [5];
        logic [3:0] er [5];
        logic [3:0] ei [5];
        int idx = 0, ridx = 0;
        bit stalled = 0, saw_low = 0;
        logic [3:0] held_re = 4'b0, held_im = 4'b0;
        re_t = '{8'sd8, 8'sd24, 8'sd32, 8'sd48, 8'sd64};
        im_t = '{-8'sd8, -8'sd24, -8'sd32, -8'sd48, -8'sd64};
        er = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110};
        ei = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110};
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_real !== held_re || out_imag !== held_im) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got=%b %b/%b exp=1 %b/%b", cyc, out_valid, out_real, out_imag, held_re, held_im);
                end
            end
            in_valid  = (idx < 5);
            in_real   = (idx < 5) ? re_t[idx] : 8'sd0;
            in_imag   = (idx < 5) ? im_t[idx] : 8'sd0;
            out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (!in_ready) saw_low = 1;
            if (out_valid && out_ready) begin
                checks++;
                if (ridx >= 5) begin
                    failures++; $display("FAIL b2b_duplicate got=%b/%b exp=none", out_real, out_imag);
                end else if (out_real !== er[ridx] || out_imag !== ei[ridx]) begin
                    failures++; $display("FAIL b2b_out[%0d] got=%b/%b exp=%b/%b", ridx, out_real, out_imag, er[ridx], ei[ridx]);
                end
                ridx++;
            end
            stalled = out_valid && !out_ready;
            held_re = out_real;
            held_im = out_imag;
            if (in_valid && in_ready) idx++;
            step();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        checks++; if (!saw_low) begin failures++; $display("FAIL b2b_in_ready got=never_low exp=low_when_full"); end
        checks++; if (ridx != 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", ridx); end
        checks++; if (idx != 5) begin failures++; $display("FAIL b2b_accepted got=%0d exp=5", idx); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_real = 8'sd127; in_imag = -8'sd128; in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_full got=v%b r%b exp=v1 r0", out_valid, in_ready); end
        checks++; if (sat_count !== 16'd2) begin failures++; $display("FAIL mid_pre_count got=%0d exp=2", sat_count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_real !== 4'b0000 || out_imag !== 4'b0000)
            begin failures++; $display("FAIL mid_reset_out got=%b %b/%b exp=0 0000/0000", out_valid, out_real, out_imag); end
        checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL mid_reset_count got=%0d exp=0", sat_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale cyc=%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_saturation();
        test_clamp_and_clear();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
